// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - request/response bus between clients and the shared shifter arbiter
interface shift_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ*3-1:0] req_amt;
  logic [NUM_REQ-1:0]   req_dir;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_data, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one 8-bit barrel shifter; SHIFT_ARB_STATS_EN adds grant_cnt
module barrel_shifter (
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  input  logic       dir_i,
  output logic [7:0] data_o
);
  // Logical, zero-filled shift; dir_i=1 shifts right.
  always_comb begin
    data_o = dir_i ? (data_i >> amt_i) : (data_i << amt_i);
  end
endmodule

module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_arbiter_if.slave bus
`ifdef SHIFT_ARB_STATS_EN
  , output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      op_data_q, op_data_d;
  logic [2:0]      op_amt_q, op_amt_d;
  logic            op_dir_q, op_dir_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic            accept;
  logic [7:0]      sel_data;
  logic [2:0]      sel_amt;
  logic            sel_dir;
  logic [7:0]      shift_out;
  logic [NUM_REQ-1:0] ready;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : p_arb
    logic [ID_W:0]   t;
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    t         = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (t >= (ID_W+1)'(NUM_REQ)) t = t - (ID_W+1)'(NUM_REQ);
      idx = t[ID_W-1:0];
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && win_found;

  // Payload mux for the winning requester.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win_idx) begin
        sel_data = bus.req_data[8*k +: 8];
        sel_amt  = bus.req_amt[3*k +: 3];
        sel_dir  = bus.req_dir[k];
      end
    end
  end

  // Grant is combinational in IDLE and suppressed while reset is held.
  always_comb begin
    ready = '0;
    if (accept && rst_n) ready[win_idx] = 1'b1;
  end

  assign bus.req_ready = ready;

  barrel_shifter u_shifter (
    .data_i (op_data_q),
    .amt_i  (op_amt_q),
    .dir_i  (op_dir_q),
    .data_o (shift_out)
  );

  // Sequencing: accept in IDLE, register shifter output in SHIFT, hold in RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_data_d   = op_data_q;
    op_amt_d    = op_amt_q;
    op_dir_d    = op_dir_q;
    op_id_d     = op_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          op_data_d = sel_data;
          op_amt_d  = sel_amt;
          op_dir_d  = sel_dir;
          op_id_d   = win_idx;
          rr_ptr_d  = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rsp_data_d  = shift_out;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_data_q   <= '0;
      op_amt_q    <= '0;
      op_dir_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_data_q   <= op_data_d;
      op_amt_q    <= op_amt_d;
      op_dir_q    <= op_dir_d;
      op_id_q     <= op_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  // Saturating per-requester grant count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q[win_idx] != 16'hFFFF) cnt_d[win_idx] = cnt_q[win_idx] + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard testbench for shift_arbiter
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus();

`ifdef SHIFT_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  shift_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SHIFT_ARB_STATS_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int grants = 0;
  int cont_left = 0;
  logic [9:0] sb_q[$];
  int exp_grant_q[$];
  logic [7:0] exp_tab[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: actual id=%0d data=%0h required=no response", bus.rsp_id, bus.rsp_data);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e[9:8]));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
        end
      end
    end
  endtask

  task automatic req(input int i, input logic [7:0] d, input logic [2:0] a, input logic dir, input logic [7:0] e);
    bus.req_data[8*i +: 8] = d;
    bus.req_amt[3*i +: 3]  = a;
    bus.req_dir[i]         = dir;
    exp_tab[i]             = e;
    bus.req_valid[i]       = 1'b1;
  endtask

  task automatic step();
    logic [3:0] g;
    int idx;
    int eg;
    idx = 0;
    @(negedge clk);
    g = bus.req_ready;
    if (g != 4'd0) begin
      chk("grant_onehot", 32'($countones(g)), 32'd1);
      chk("grant_subset", 32'(g & ~bus.req_valid), 32'd0);
      for (int k = 0; k < 4; k++) if (g[k]) idx = k;
      sb_q.push_back({idx[1:0], exp_tab[idx]});
      if (exp_grant_q.size() != 0) begin
        eg = exp_grant_q.pop_front();
        chk("grant_order", 32'(idx), 32'(eg));
      end
      grants++;
    end
    @(posedge clk);
    #1;
    if (g != 4'd0) begin
      if (cont_left > 0) begin
        cont_left--;
        if (cont_left == 0) bus.req_valid = '0;
      end else begin
        bus.req_valid[idx] = 1'b0;
      end
    end
  endtask

  task automatic wait_grant(input int maxc);
    int n;
    int start;
    n = 0;
    start = grants;
    while (grants == start && n < maxc) begin
      step();
      n++;
    end
    chk("grant_timeout", 32'(grants == start), 32'd0);
  endtask

  task automatic run_until(input int maxc);
    int n;
    n = 0;
    while ((bus.req_valid != 4'd0 || sb_q.size() != 0 || bus.rsp_valid) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= maxc), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    sb_q.delete();
    exp_grant_q.delete();
    cont_left = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_dir   = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_tab[i] = 8'h00;
    fork
      monitor();
    join_none

    // Reset state, with requests asserted during reset
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request and latency
    exp_grant_q.push_back(0);
    req(0, 8'hB5, 3'd3, 1'b0, 8'hA8);
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    wait_grant(10);
    chk("lat_shift_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
    run_until(20);

    // Shift boundaries
    exp_grant_q.push_back(2);
    req(2, 8'h81, 3'd7, 1'b1, 8'h01);
    run_until(20);
    req(1, 8'h3C, 3'd0, 1'b0, 8'h3C);
    run_until(20);
    req(3, 8'hC3, 3'd0, 1'b1, 8'hC3);
    run_until(20);
    req(0, 8'h81, 3'd7, 1'b0, 8'h80);
    run_until(20);

    // Continuous requests from all four, round-robin with wrap
    do_reset();
    exp_grant_q = '{0, 1, 2, 3, 0, 1};
    cont_left = 6;
    req(0, 8'h01, 3'd1, 1'b0, 8'h02);
    req(1, 8'h80, 3'd1, 1'b1, 8'h40);
    req(2, 8'hF0, 3'd4, 1'b0, 8'h00);
    req(3, 8'h0F, 3'd2, 1'b1, 8'h03);
    run_until(60);
    chk("cont_grants", 32'(grants), 32'd11);

    // Backpressure
    bus.rsp_ready = 1'b0;
    exp_grant_q.push_back(0);
    req(0, 8'h5A, 3'd2, 1'b1, 8'h16);
    wait_grant(10);
    for (int n = 0; n < 10 && !bus.rsp_valid; n++) step();
    chk("bp_reach_resp", 32'(bus.rsp_valid), 32'd1);
    req(2, 8'h81, 3'd7, 1'b1, 8'h01);
    req(3, 8'hC3, 3'd0, 1'b1, 8'hC3);
    exp_grant_q.push_back(2);
    exp_grant_q.push_back(3);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data), 32'h16);
      chk("bp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    run_until(40);

    // Reset while in SHIFT
    exp_grant_q.push_back(2);
    req(2, 8'h81, 3'd7, 1'b1, 8'h01);
    wait_grant(10);
    rst_n = 1'b0;
    req(1, 8'h3C, 3'd0, 1'b0, 8'h3C);
    req(3, 8'h0F, 3'd2, 1'b1, 8'h03);
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
    sb_q.delete();
    exp_grant_q.delete();
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until(40);

`ifdef SHIFT_ARB_STATS_EN
    // Grant statistics and saturation
    do_reset();
    for (int n = 0; n < 3; n++) begin
      req(1, 8'h01, 3'd1, 1'b0, 8'h02);
      run_until(20);
    end
    chk("cnt_req1", 32'(grant_cnt[31:16]), 32'd3);
    chk("cnt_req0", 32'(grant_cnt[15:0]), 32'd0);
    chk("cnt_req2", 32'(grant_cnt[47:32]), 32'd0);
    chk("cnt_req3", 32'(grant_cnt[63:48]), 32'd0);
    force dut.cnt_q[1] = 16'hFFFE;
    #1;
    release dut.cnt_q[1];
    for (int n = 0; n < 2; n++) begin
      req(1, 8'h01, 3'd1, 1'b0, 8'h02);
      run_until(20);
    end
    chk("cnt_saturate", 32'(grant_cnt[31:16]), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
